// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock over WIDTH/DIGIT
// cycles and presents the result with a valid/ready handshake.
module serial_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned N     = WIDTH / DIGIT;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DW    = DIGIT + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_nxt;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic             carry;
   logic             cout_r;
   logic             ovf_r;
   logic             a_msb;
   logic             b_msb;
   logic [DW-1:0]    dsum_full;

   // One digit of addition and the shifted-in result word
   always_comb begin
      dsum_full = DW'(a_sh[DIGIT-1:0]) + DW'(b_sh[DIGIT-1:0]) + DW'(carry);
      res_nxt   = (res >> DIGIT) | (WIDTH'(dsum_full[DIGIT-1:0]) << (WIDTH - DIGIT));
      cnt_last  = (cnt == CNT_W'(N - 1));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (cnt_last)  state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state only
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand capture, digit-serial datapath and final flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res    <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
                  a_msb <= a[WIDTH-1];
                  b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
               end
            end
            RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               res   <= res_nxt;
               carry <= dsum_full[DIGIT];
               cnt   <= cnt + CNT_W'(1);
               if (cnt_last) begin
                  cout_r <= dsum_full[DIGIT];
                  ovf_r  <= (a_msb == b_msb) && (dsum_full[DIGIT-1] != a_msb);
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = res;
   assign cout = cout_r;
   assign ovf  = ovf_r;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, bits added per clock; WIDTH SHALL be an integer multiple of DIGIT (N = WIDTH/DIGIT).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used only when sub=0.
REQ-010 sub  input  1  0: A+B+cin; 1: A-B.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB (sub=1: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 IDLE: on clk edge with in_valid=1, the block SHALL capture a, b_eff (b if sub=0, ~b if sub=1), and carry (cin if sub=0, 1 if sub=1), clear digit counter, go to RUN; otherwise stay IDLE.
REQ-018 RUN: each cycle the block SHALL add DIGIT LSBs of A, DIGIT LSBs of b_eff and the carry register, shift A and b_eff right by DIGIT, shift the DIGIT-bit partial sum into the result register from the MSB end, update carry, increment counter.
REQ-019 After exactly N RUN cycles the block SHALL enter DONE; out_valid SHALL be visible after the Nth edge following the accepting edge (latency N cycles).
REQ-020 DONE: sum = full WIDTH result, cout = final carry, ovf = (A[MSB]==b_eff[MSB]) and (sum[MSB]!=A[MSB]) using the originally captured MSBs.
REQ-021 DONE: sum, cout, ovf SHALL hold stable until out_valid && out_ready at a clk edge, then go to IDLE.
REQ-022 in_valid during RUN or DONE SHALL be ignored (no capture, no state change); minimum operation period N+2 cycles.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; cout is the (WIDTH+1)th bit; no saturation.
REQ-024 DIGIT=WIDTH (N=1) SHALL be legal: one RUN cycle, then DONE.
REQ-025 WIDTH=1, DIGIT=1, sub=0 SHALL behave as a registered 1-bit full adder: sum = a^b^cin, cout = majority(a,b,cin).
REQ-026 Outputs in_ready, out_valid SHALL be driven directly from state registers (no combinational path from in_valid/out_ready).

Reset
REQ-027 rst=1 at a clk edge SHALL force state IDLE, counter 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0, in_ready 1 after that edge, overriding any simultaneous handshake.
REQ-028 rst asserted during RUN or DONE SHALL discard the operation in progress; no result is ever presented for it.
REQ-029 First operation after rst deassertion SHALL be acceptable on the first edge with rst=0.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-030 a=0x1234, b=0x4321, cin=0, sub=0 -> after 4 cycles out_valid=1, sum=0x5555, cout=0, ovf=0.
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-032 sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-033 out_ready held 0 for 3 cycles in DONE with in_valid=1 and new operands -> sum/cout/ovf unchanged, in_ready=0; out_ready=1 -> IDLE next edge, then new operands accepted.
REQ-034 rst pulsed for one cycle at RUN cycle 2 -> next cycle in_ready=1, out_valid=0, sum=0; no out_valid for the aborted operation.
REQ-035 WIDTH=1, DIGIT=1: all 8 (a,b,cin) combinations -> sum/cout match full-adder truth table after 1 cycle each.
